// File: rtl/fpu_pkg.sv
// ----------------------------------------------------------------------------
// fpu_pkg
// Shared types and constants for the single-precision rounding datapath:
// rounding-mode encoding, fflags bit positions, special encodings, the
// rounder FSM state and operand class enums, and the overflow-direction helper.
// ----------------------------------------------------------------------------
package fpu_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rm_e;

    // fflags = {NV, DZ, OF, UF, NX}
    localparam int FF_NX = 0;
    localparam int FF_UF = 1;
    localparam int FF_OF = 2;
    localparam int FF_DZ = 3;
    localparam int FF_NV = 4;

    localparam logic [9:0]  EXP_INF    = 10'h0FF;
    localparam logic [31:0] CANON_NAN  = 32'h7FC00000;
    localparam logic [31:0] MAX_FINITE = 32'h7F7FFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SHIFT,
        ST_ROUND
    } state_e;

    // Operand class, decided once in CAPTURE so later shifting cannot
    // disturb it (a long subnormal shift can leave the mantissa all zero).
    typedef enum logic [1:0] {
        CLS_NORMAL,
        CLS_TINY,
        CLS_ZERO,
        CLS_SPECIAL
    } class_e;

    // On overflow: does the rounding direction reach infinity, or stop at
    // the largest finite magnitude? Reserved modes behave as RNE.
    function automatic logic overflow_to_inf(input logic sign, input logic [2:0] rm);
        case (rm)
            RM_RTZ:  return 1'b0;
            RM_RDN:  return sign;
            RM_RUP:  return ~sign;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/float_round_inc.sv
// ----------------------------------------------------------------------------
// float_round_inc
// Combinational increment decision for IEEE-754 rounding.
//   sign   : operand sign
//   rm     : rounding mode (reserved codes behave as RNE)
//   lsb    : least significant kept mantissa bit (for ties-to-even)
//   round  : guard bit just below the lsb
//   sticky : OR of every bit below the guard bit
//   inc    : 1 when the kept mantissa must be incremented by one ulp
// ----------------------------------------------------------------------------
module float_round_inc
    import fpu_pkg::*;
(
    input  logic       sign,
    input  logic [2:0] rm,
    input  logic       lsb,
    input  logic       round,
    input  logic       sticky,
    output logic       inc
);

    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        inc = 1'b0;
        case (rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & (round | sticky);
            RM_RUP:  inc = ~sign & (round | sticky);
            RM_RMM:  inc = round;
            default: inc = round & (sticky | lsb);
        endcase
    end

endmodule

// File: rtl/float_rounder.sv
// ----------------------------------------------------------------------------
// float_rounder
// Multi-cycle rounder producing an IEEE-754 single from an unrounded
// mantissa/exponent with guard and sticky bits.
//
// FSM: IDLE -> CAPTURE -> (SHIFT) -> ROUND -> IDLE. A load in any state
// aborts the current operation and restarts from CAPTURE.
//
// Build option FLOAT_ROUNDER_SUBNORMAL_EN:
//   defined   : tiny operands are denormalised in SHIFT, one right shift per
//               cycle, min(1-exp_in, MAX_SHIFT) cycles, then rounded.
//   undefined : tiny operands flush to signed zero with UF|NX; no SHIFT state.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   load                one-cycle operand capture pulse
//   man_in[23:0]        mantissa, hidden bit at [23]
//   exp_in[9:0]         biased exponent, two's complement
//   sgn_in              sign
//   round_bit           guard bit
//   sticky_bit          sticky bit
//   final_res           special result, passed through without rounding
//   IV, DZ              upstream invalid / divide-by-zero flags
//   rm[2:0]             rounding mode
//   result[31:0]        rounded single-precision result
//   fflags[4:0]         {NV, DZ, OF, UF, NX}
//   valid               one-cycle result pulse
//   busy                operation in flight
// ----------------------------------------------------------------------------
module float_rounder
    import fpu_pkg::*;
#(
    parameter int MAX_SHIFT = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [23:0] man_in,
    input  logic [9:0]  exp_in,
    input  logic        sgn_in,
    input  logic        round_bit,
    input  logic        sticky_bit,
    input  logic        final_res,
    input  logic        IV,
    input  logic        DZ,
    input  logic [2:0]  rm,
    output logic [31:0] result,
    output logic [4:0]  fflags,
    output logic        valid,
    output logic        busy
);

    state_e      state;
    class_e      cls_r;
    class_e      cls_next;
    logic [23:0] man_r;
    logic [9:0]  exp_r;
    logic        sgn_r;
    logic        rb_r;
    logic        sb_r;
    logic        fr_r;
    logic        iv_r;
    logic        dz_r;
    logic [2:0]  rm_r;

    logic        round_up;
    logic        inexact;
    logic        frac_carry;
    logic [22:0] frac_sum;
    logic [9:0]  exp_post;
    logic [31:0] res_next;
    logic [4:0]  flags_next;

`ifdef FLOAT_ROUNDER_SUBNORMAL_EN
    localparam int CNT_W = $clog2(MAX_SHIFT + 1);

    logic [CNT_W-1:0] shift_cnt;
    logic [CNT_W-1:0] shift_amt;
    logic [10:0]      shift_need;

    // Only evaluated for tiny operands (exp <= 0), so 1 - exp is positive.
    assign shift_need = 11'd1 - {exp_r[9], exp_r};
    assign shift_amt  = (shift_need > 11'(MAX_SHIFT)) ? CNT_W'(MAX_SHIFT)
                                                      : shift_need[CNT_W-1:0];
`endif

    // Classification of the captured operand.
    always_comb begin
        cls_next = CLS_NORMAL;
        if (fr_r)
            cls_next = CLS_SPECIAL;
        else if (man_r == '0)
            cls_next = CLS_ZERO;
        else if (exp_r[9] || exp_r == '0)
            cls_next = CLS_TINY;
    end

    float_round_inc u_round_inc (
        .sign   (sgn_r),
        .rm     (rm_r),
        .lsb    (man_r[0]),
        .round  (rb_r),
        .sticky (sb_r),
        .inc    (round_up)
    );

    // Adding on the 23-bit fraction: a carry out means the mantissa wrapped
    // from 0xFFFFFF to 0x800000 (exponent + 1), or that a subnormal became
    // the smallest normal (exponent field 1). frac_sum is already 0 then.
    assign {frac_carry, frac_sum} = {1'b0, man_r[22:0]} + {23'b0, round_up};
    assign inexact  = rb_r | sb_r;
    // Normal operands have exp_r in 1..511, so this cannot wrap.
    assign exp_post = exp_r + {9'b0, frac_carry};

    always_comb begin
        res_next           = {sgn_r, 31'b0};
        flags_next         = '0;
        flags_next[FF_NV]  = iv_r;
        flags_next[FF_DZ]  = dz_r & ~iv_r;
        case (cls_r)
            CLS_SPECIAL: begin
                if (exp_r == EXP_INF && man_r[22])
                    res_next = CANON_NAN;
                else if (exp_r == EXP_INF && man_r == 24'h800000)
                    res_next = {sgn_r, 8'hFF, 23'b0};
                else if (man_r == '0)
                    res_next = {sgn_r, 31'b0};
                else
                    res_next = {sgn_r, exp_r[7:0], man_r[22:0]};
            end
            CLS_ZERO: begin
                res_next = {sgn_r, 31'b0};
            end
            CLS_TINY: begin
`ifdef FLOAT_ROUNDER_SUBNORMAL_EN
                // Tininess was decided before rounding, so UF needs only inexact.
                res_next          = {sgn_r, 7'b0, frac_carry, frac_sum};
                flags_next[FF_UF] = inexact;
                flags_next[FF_NX] = inexact;
`else
                res_next          = {sgn_r, 31'b0};
                flags_next[FF_UF] = 1'b1;
                flags_next[FF_NX] = 1'b1;
`endif
            end
            default: begin
                if (exp_post >= 10'd255) begin
                    res_next = overflow_to_inf(sgn_r, rm_r) ? {sgn_r, 8'hFF, 23'b0}
                                                            : {sgn_r, MAX_FINITE[30:0]};
                    flags_next[FF_OF] = 1'b1;
                    flags_next[FF_NX] = 1'b1;
                end else begin
                    res_next          = {sgn_r, exp_post[7:0], frac_sum};
                    flags_next[FF_NX] = inexact;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            cls_r  <= CLS_NORMAL;
            man_r  <= '0;
            exp_r  <= '0;
            sgn_r  <= 1'b0;
            rb_r   <= 1'b0;
            sb_r   <= 1'b0;
            fr_r   <= 1'b0;
            iv_r   <= 1'b0;
            dz_r   <= 1'b0;
            rm_r   <= '0;
            result <= '0;
            fflags <= '0;
            valid  <= 1'b0;
            busy   <= 1'b0;
`ifdef FLOAT_ROUNDER_SUBNORMAL_EN
            shift_cnt <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            valid <= 1'b0;
            if (load) begin
                man_r <= man_in;
                exp_r <= exp_in;
                sgn_r <= sgn_in;
                rb_r  <= round_bit;
                sb_r  <= sticky_bit;
                fr_r  <= final_res;
                iv_r  <= IV;
                dz_r  <= DZ;
                rm_r  <= rm;
                busy  <= 1'b1;
                state <= ST_CAPTURE;
            end else begin
                case (state)
                    ST_CAPTURE: begin
                        cls_r <= cls_next;
`ifdef FLOAT_ROUNDER_SUBNORMAL_EN
                        if (cls_next == CLS_TINY) begin
                            shift_cnt <= shift_amt;
                            state     <= ST_SHIFT;
                        end else begin
                            state <= ST_ROUND;
                        end
`else
                        state <= ST_ROUND;
`endif
                    end
`ifdef FLOAT_ROUNDER_SUBNORMAL_EN
                    ST_SHIFT: begin
                        // The old guard bit joins sticky; the mantissa lsb becomes the guard.
                        man_r     <= man_r >> 1;
                        rb_r      <= man_r[0];
                        sb_r      <= sb_r | rb_r;
                        shift_cnt <= shift_cnt - CNT_W'(1);
                        if (shift_cnt == CNT_W'(1))
                            state <= ST_ROUND;
                    end
`endif
                    ST_ROUND: begin
                        result <= res_next;
                        fflags <= flags_next;
                        valid  <= 1'b1;
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_float_rounder.sv
`timescale 1ns/1ps
module tb_float_rounder;

    localparam int MAX_SHIFT = 25;
    localparam logic [4:0] F_NV = 5'b10000;
    localparam logic [4:0] F_DZ = 5'b01000;
    localparam logic [4:0] F_OF = 5'b00100;
    localparam logic [4:0] F_UF = 5'b00010;
    localparam logic [4:0] F_NX = 5'b00001;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [23:0] man_in;
    logic [9:0]  exp_in;
    logic        sgn_in;
    logic        round_bit;
    logic        sticky_bit;
    logic        final_res;
    logic        IV;
    logic        DZ;
    logic [2:0]  rm;
    logic [31:0] result;
    logic [4:0]  fflags;
    logic        valid;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    float_rounder #(.MAX_SHIFT(MAX_SHIFT)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .man_in     (man_in),
        .exp_in     (exp_in),
        .sgn_in     (sgn_in),
        .round_bit  (round_bit),
        .sticky_bit (sticky_bit),
        .final_res  (final_res),
        .IV         (IV),
        .DZ         (DZ),
        .rm         (rm),
        .result     (result),
        .fflags     (fflags),
        .valid      (valid),
        .busy       (busy)
    );

    typedef struct {
        logic [23:0] man;
        logic [9:0]  ex;
        logic        sgn;
        logic        rb;
        logic        sb;
        logic [2:0]  rm;
        logic        fr;
        logic        iv;
        logic        dz;
    } op_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flags;
        int          lat;
    } exp_t;

    typedef struct {
        string       name;
        op_t         o;
        logic [31:0] res;
        logic [4:0]  flags;
        int          lat;
    } dir_t;

    function automatic op_t mk(logic [23:0] man, logic [9:0] ex, logic sgn, logic rb, logic sb,
                               logic [2:0] rmode, logic fr, logic iv, logic dz);
        op_t o;
        o.man = man; o.ex = ex; o.sgn = sgn; o.rb = rb; o.sb = sb;
        o.rm = rmode; o.fr = fr; o.iv = iv; o.dz = dz;
        return o;
    endfunction

    function automatic dir_t dv(string n, op_t o, logic [31:0] r, logic [4:0] f, int l);
        dir_t d;
        d.name = n; d.o = o; d.res = r; d.flags = f; d.lat = l;
        return d;
    endfunction

    // Reference: the value is treated as an integer mantissa with a guard
    // bit and a sticky flag; denormalising is one arithmetic shift by S.
    function automatic exp_t model(input op_t o);
        exp_t   r;
        int     e;
        int     mode;
        longint m;
        bit     rnd, stk, inc, to_inf;
        e       = int'($signed(o.ex));
        r.lat   = 2;
        r.flags = 5'b0;
        r.res   = {o.sgn, 31'h0};
        if (o.iv) r.flags |= F_NV;
        else if (o.dz) r.flags |= F_DZ;
        if (o.fr) begin
            if (o.ex == 10'h0FF && o.man[22]) r.res = 32'h7FC00000;
            else if (o.ex == 10'h0FF && o.man == 24'h800000) r.res = {o.sgn, 31'h7F800000};
            else if (o.man == 24'h0) r.res = {o.sgn, 31'h0};
            else r.res = {o.sgn, o.ex[7:0], o.man[22:0]};
            return r;
        end
        if (o.man == 24'h0) return r;
        m   = longint'(o.man);
        rnd = o.rb;
        stk = o.sb;
        if (e <= 0) begin
`ifdef FLOAT_ROUNDER_SUBNORMAL_EN
            int     s;
            longint sig;
            s     = (1 - e > MAX_SHIFT) ? MAX_SHIFT : 1 - e;
            sig   = (m << 1) | longint'(o.rb);
            m     = sig >> (s + 1);
            rnd   = ((sig >> s) & 64'd1) != 0;
            stk   = o.sb || ((sig & ((longint'(1) << s) - 1)) != 0);
            r.lat = 2 + s;
`else
            r.flags |= F_UF | F_NX;
            return r;
`endif
        end
        mode = (o.rm > 3'd4) ? 0 : int'(o.rm);
        case (mode)
            0:       inc = rnd && (stk || (m % 2 == 1));
            1:       inc = 0;
            2:       inc = o.sgn && (rnd || stk);
            3:       inc = !o.sgn && (rnd || stk);
            default: inc = rnd;
        endcase
        m = m + (inc ? 64'd1 : 64'd0);
        if (e <= 0) begin
            r.res = {o.sgn, (m >= 64'h800000) ? 8'd1 : 8'd0, 23'(m)};
            if (rnd || stk) r.flags |= F_UF | F_NX;
            return r;
        end
        if (m >= 64'h1000000) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e >= 255) begin
            to_inf = (mode == 0) || (mode == 4) || (mode == 3 && !o.sgn) || (mode == 2 && o.sgn);
            r.res  = to_inf ? {o.sgn, 31'h7F800000} : {o.sgn, 31'h7F7FFFFF};
            r.flags |= F_OF | F_NX;
        end else begin
            r.res = {o.sgn, 8'(e), 23'(m)};
            if (rnd || stk) r.flags |= F_NX;
        end
        return r;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int  sel;
        sel   = int'($urandom_range(0, 11));
        o.man = 24'($urandom) | 24'h800000;
        o.sgn = 1'($urandom);
        o.rb  = 1'($urandom);
        o.sb  = 1'($urandom);
        o.rm  = 3'($urandom_range(0, 7));
        o.fr  = 1'b0;
        o.iv  = ($urandom_range(0, 7) == 0);
        o.dz  = ($urandom_range(0, 7) == 0);
        o.ex  = 10'($urandom_range(1, 254));
        case (sel)
            5: o.ex = 10'($urandom_range(250, 300));
            6: begin o.man = 24'hFFFFFF; o.ex = 10'($urandom_range(1, 255)); end
            7, 8: begin
                o.man = 24'($urandom_range(1, 24'hFFFFFF));
                o.ex  = 10'(-int'($urandom_range(0, 30)));
            end
            9: begin o.man = 24'h0; o.ex = 10'($urandom); end
            10: begin
                o.fr = 1'b1;
                case ($urandom_range(0, 3))
                    0: begin o.ex = 10'h0FF; o.man[22] = 1'b1; end
                    1: begin o.ex = 10'h0FF; o.man = 24'h800000; end
                    2: o.man = 24'h0;
                    default: ;
                endcase
            end
            default: ;
        endcase
        return o;
    endfunction

    task automatic scramble_inputs();
        man_in     = 24'($urandom);
        exp_in     = 10'($urandom);
        sgn_in     = 1'($urandom);
        round_bit  = 1'($urandom);
        sticky_bit = 1'($urandom);
        final_res  = 1'($urandom);
        IV         = 1'($urandom);
        DZ         = 1'($urandom);
        rm         = 3'($urandom);
    endtask

    task automatic drive_load(input op_t o);
        man_in = o.man; exp_in = o.ex; sgn_in = o.sgn;
        round_bit = o.rb; sticky_bit = o.sb; final_res = o.fr;
        IV = o.iv; DZ = o.dz; rm = o.rm;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        scramble_inputs();
    endtask

    // Loads one operand (called #1 after an edge) and waits for valid.
    // lat counts edges after the load edge; -1 on timeout.
    task automatic do_op(input op_t o, output logic [31:0] res, output logic [4:0] fl,
                         output int lat, output bit busy_ok);
        busy_ok = 1'b1;
        lat     = -1;
        res     = 'x;
        fl      = 'x;
        drive_load(o);
        if (valid) begin
            lat = 0; res = result; fl = fflags;
            return;
        end
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (valid && busy) busy_ok = 1'b0;
            if (valid) begin
                lat = k; res = result; fl = fflags;
                return;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        n_vec++;
        if (result !== 32'h0 || fflags !== 5'h0 || valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got result=%h fflags=%b valid=%b busy=%b, want 0/0/0/0",
                     result, fflags, valid, busy);
        end
    endtask

    task automatic test_directed();
        dir_t tbl[$];
        logic [31:0] r;
        logic [4:0]  f;
        int          l;
        bit          bok;
        tbl.push_back(dv("one_rne",       mk(24'h800000, 10'd127, 0, 0, 0, 3'd0, 0, 0, 0), 32'h3F800000, 5'h0, 2));
        tbl.push_back(dv("tie_rne",       mk(24'h800001, 10'd127, 0, 1, 0, 3'd0, 0, 0, 0), 32'h3F800002, F_NX, 2));
        tbl.push_back(dv("tie_rtz",       mk(24'h800001, 10'd127, 0, 1, 0, 3'd1, 0, 0, 0), 32'h3F800001, F_NX, 2));
        tbl.push_back(dv("man_carry",     mk(24'hFFFFFF, 10'd127, 0, 1, 0, 3'd0, 0, 0, 0), 32'h40000000, F_NX, 2));
        tbl.push_back(dv("ovf_rne",       mk(24'h800000, 10'd255, 0, 0, 0, 3'd0, 0, 0, 0), 32'h7F800000, F_OF | F_NX, 2));
        tbl.push_back(dv("ovf_rtz",       mk(24'h800000, 10'd255, 0, 0, 0, 3'd1, 0, 0, 0), 32'h7F7FFFFF, F_OF | F_NX, 2));
        tbl.push_back(dv("ovf_rdn_pos",   mk(24'h800000, 10'd255, 0, 0, 0, 3'd2, 0, 0, 0), 32'h7F7FFFFF, F_OF | F_NX, 2));
        tbl.push_back(dv("ovf_rdn_neg",   mk(24'h800000, 10'd255, 1, 0, 0, 3'd2, 0, 0, 0), 32'hFF800000, F_OF | F_NX, 2));
        tbl.push_back(dv("ovf_rup_neg",   mk(24'h800000, 10'd255, 1, 0, 0, 3'd3, 0, 0, 0), 32'hFF7FFFFF, F_OF | F_NX, 2));
        tbl.push_back(dv("final_nan_nv",  mk(24'hC00000, 10'h0FF, 0, 0, 0, 3'd0, 1, 1, 0), 32'h7FC00000, F_NV, 2));
        tbl.push_back(dv("final_neg_inf", mk(24'h800000, 10'h0FF, 1, 0, 0, 3'd0, 1, 0, 0), 32'hFF800000, 5'h0, 2));
        tbl.push_back(dv("final_inf_dz",  mk(24'h800000, 10'h0FF, 0, 0, 0, 3'd0, 1, 0, 1), 32'h7F800000, F_DZ, 2));
        tbl.push_back(dv("iv_masks_dz",   mk(24'h800000, 10'h0FF, 0, 0, 0, 3'd0, 1, 1, 1), 32'h7F800000, F_NV, 2));
        tbl.push_back(dv("neg_zero",      mk(24'h000000, 10'd3,   1, 1, 1, 3'd0, 0, 0, 0), 32'h80000000, 5'h0, 2));
        tbl.push_back(dv("rmm_tie",       mk(24'h800000, 10'd127, 1, 1, 0, 3'd4, 0, 0, 0), 32'hBF800001, F_NX, 2));
        tbl.push_back(dv("reserved_rm",   mk(24'h800001, 10'd127, 0, 1, 0, 3'd7, 0, 0, 0), 32'h3F800002, F_NX, 2));
`ifdef FLOAT_ROUNDER_SUBNORMAL_EN
        tbl.push_back(dv("sub_exp_m1",    mk(24'h800000, 10'h3FF, 0, 0, 0, 3'd0, 0, 0, 0), 32'h00200000, 5'h0, 4));
        tbl.push_back(dv("sub_to_min_nrm",mk(24'hFFFFFF, 10'h000, 0, 1, 0, 3'd0, 0, 0, 0), 32'h00800000, F_UF | F_NX, 3));
        tbl.push_back(dv("max_shift_rne", mk(24'h800000, 10'h39C, 0, 0, 0, 3'd0, 0, 0, 0), 32'h00000000, F_UF | F_NX, 27));
        tbl.push_back(dv("max_shift_rup", mk(24'h800000, 10'h39C, 0, 0, 0, 3'd3, 0, 0, 0), 32'h00000001, F_UF | F_NX, 27));
`else
        tbl.push_back(dv("flush_exp_m1",  mk(24'h800000, 10'h3FF, 0, 0, 0, 3'd0, 0, 0, 0), 32'h00000000, F_UF | F_NX, 2));
        tbl.push_back(dv("flush_neg",     mk(24'hFFFFFF, 10'h000, 1, 1, 0, 3'd0, 0, 0, 0), 32'h80000000, F_UF | F_NX, 2));
`endif
        foreach (tbl[i]) begin
            do_op(tbl[i].o, r, f, l, bok);
            n_vec++;
            if (r !== tbl[i].res) begin
                n_bad++;
                $display("FAIL %s result: got %h want %h", tbl[i].name, r, tbl[i].res);
            end
            n_vec++;
            if (f !== tbl[i].flags) begin
                n_bad++;
                $display("FAIL %s fflags: got %b want %b", tbl[i].name, f, tbl[i].flags);
            end
            n_vec++;
            if (l !== tbl[i].lat) begin
                n_bad++;
                $display("FAIL %s latency: got %0d want %0d", tbl[i].name, l, tbl[i].lat);
            end
            n_vec++;
            if (bok !== 1'b1) begin
                n_bad++;
                $display("FAIL %s busy_protocol: got bad busy/valid overlap, want busy until valid", tbl[i].name);
            end
        end
    endtask

    task automatic test_random();
        op_t         o;
        exp_t        e;
        logic [31:0] r;
        logic [4:0]  f;
        int          l;
        bit          bok;
        for (int i = 0; i < 300; i++) begin
            o = rand_op();
            e = model(o);
            do_op(o, r, f, l, bok);
            n_vec++;
            if (r !== e.res || f !== e.flags || l !== e.lat || bok !== 1'b1) begin
                n_bad++;
                $display("FAIL random[%0d] man=%h exp=%h s=%b rb=%b sb=%b rm=%0d fr=%b: got %h/%b/lat%0d/busy_ok%0d want %h/%b/lat%0d",
                         i, o.man, o.ex, o.sgn, o.rb, o.sb, o.rm, o.fr, r, f, l, bok, e.res, e.flags, e.lat);
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] r;
        logic [4:0]  f;
        int          l;
        bit          bok;
        do_op(mk(24'hABCDEF, 10'd100, 1, 1, 1, 3'd3, 0, 0, 0), r, f, l, bok);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            scramble_inputs();
            n_vec++;
            if (result !== r || fflags !== f || valid !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL hold[%0d]: got %h/%b valid=%b busy=%b want %h/%b valid=0 busy=0",
                         k, result, fflags, valid, busy, r, f);
            end
        end
    endtask

    task automatic test_abort();
        op_t         a, b;
        exp_t        e;
        logic [31:0] r;
        logic [4:0]  f;
        int          l;
        bit          bok;
        bit          early;
        int          extra;
        a = mk(24'h9ABCDE, 10'h3FB, 0, 1, 0, 3'd0, 0, 0, 0);
        b = mk(24'hC00000, 10'd130, 1, 0, 1, 3'd1, 0, 0, 0);
        e = model(b);
        drive_load(a);
        early = valid;
        @(posedge clk); #1;
        early |= valid;
        do_op(b, r, f, l, bok);
        extra = 0;
        for (int k = 0; k < 35; k++) begin
            @(posedge clk); #1;
            if (valid) extra++;
        end
        n_vec++;
        if (early || r !== e.res || f !== e.flags || l !== e.lat || extra != 0) begin
            n_bad++;
            $display("FAIL abort_restart: got early=%0d %h/%b lat%0d extra_valids=%0d want 0 %h/%b lat%0d 0",
                     early, r, f, l, extra, e.res, e.flags, e.lat);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        drive_load(mk(24'hFFFFFF, 10'h3EC, 0, 1, 1, 3'd0, 0, 0, 0));
`ifdef FLOAT_ROUNDER_SUBNORMAL_EN
        repeat (4) begin @(posedge clk); #1; end
`else
        @(posedge clk); #1;
`endif
        reset = 1'b1;
        #3;
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (valid || busy) seen++;
        end
        n_vec++;
        if (seen != 0 || result !== 32'h0 || fflags !== 5'h0) begin
            n_bad++;
            $display("FAIL reset_mid_op: got %0d cycles of valid/busy, result=%h fflags=%b; want 0, 0, 0",
                     seen, result, fflags);
        end
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        man_in = '0; exp_in = '0; sgn_in = 1'b0; round_bit = 1'b0; sticky_bit = 1'b0;
        final_res = 1'b0; IV = 1'b0; DZ = 1'b0; rm = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        test_directed();
        test_hold();
        test_abort();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/float_rounder.md
FLOAT_ROUNDER -- requirements
Module: float_rounder

Interface
REQ-001 SHALL have parameter MAX_SHIFT, default 25, the cap on subnormal right-shift steps; larger shifts fold all bits into sticky.
REQ-002 SHALL have ports: clk  in  1  clock (rising edge); reset  in  1  asynchronous, active-high.
REQ-003 SHALL have: load  in  1  one-cycle pulse, operand capture (driven by upstream ready).
REQ-004 SHALL have: man_in  in  24  mantissa with hidden bit at [23].
REQ-005 SHALL have: exp_in  in  10  biased exponent, two's complement.
REQ-006 SHALL have: sgn_in  in  1  sign. round_bit, sticky_bit  in  1 each  guard and sticky bits.
REQ-007 SHALL have: final_res  in  1  special result, no rounding. IV, DZ  in  1 each  upstream exception flags.
REQ-008 SHALL have: rm  in  3  rounding mode (RNE 000, RTZ 001, RDN 010, RUP 011, RMM 100).
REQ-009 SHALL have outputs: result  out  32  IEEE-754 single; fflags  out  5  {NV,DZ,OF,UF,NX}; valid  out  1  one-cycle pulse; busy  out  1  operation in flight.

Function
REQ-010 SHALL implement FSM IDLE->CAPTURE->(SHIFT)->ROUND->IDLE; load in any state SHALL abort current work and restart.
REQ-011 SHALL sample inputs and rm on the load edge; later input changes SHALL be ignored.
REQ-012 Normal path: valid SHALL be high after edge N+2 for load at edge N. Subnormal path: after edge N+2+S, with S=min(1-exp_in, MAX_SHIFT).
REQ-013 SHALL hold busy high from the edge after load until valid is asserted; valid and busy SHALL never both be high.
REQ-014 SHALL hold result/fflags stable from valid until the next load.
REQ-015 SHALL treat exp_in<=0 with man_in!=0 as subnormal: SHIFT does one right shift per cycle; shifted-out guard bits SHALL be ORed into sticky.
REQ-016 Rounding: RNE ties-to-even; RTZ truncate; RDN increment if negative and inexact; RUP increment if positive and inexact; RMM increment if round_bit. Reserved rm values SHALL behave as RNE.
REQ-017 On mantissa carry-out (0xFFFFFF+1), SHALL use mantissa 0x800000 and increment the exponent. A subnormal rounding to 0x800000 SHALL yield exponent 1.
REQ-018 Overflow when post-round exponent>=255: OF and NX SHALL be set. Result: inf for RNE/RMM, toward-zero direction for RTZ, max finite 0x7F7FFFFF in magnitude when the direction excludes inf.
REQ-019 Tininess SHALL be detected before rounding; UF SHALL be set only if tiny and inexact. NX SHALL be set when round_bit or sticky is set after shifting.
REQ-020 final_res SHALL bypass rounding. exp_in=0x0FF with man_in[22]=1 -> 0x7FC00000. exp_in=0x0FF with man_in=0x800000 -> signed inf. Zero -> signed zero.
REQ-021 fflags.NV SHALL equal captured IV; fflags.DZ SHALL equal captured DZ only if IV=0.
REQ-022 man_in=0 and final_res=0 SHALL yield signed zero with no flags.

Reset
REQ-023 On reset: state IDLE, result 0x00000000, fflags 0, valid 0, busy 0, shift counter 0.
REQ-024 Reset mid-SHIFT SHALL discard the operation; no valid SHALL follow.

Configuration
REQ-025 FLOAT_ROUNDER_SUBNORMAL_EN defined: subnormal path per REQ-015.
REQ-026 FLOAT_ROUNDER_SUBNORMAL_EN undefined: tiny results SHALL flush to signed zero with UF and NX set. No SHIFT state; latency is always 2.

Structure
REQ-027 Package fpu_pkg SHALL hold: rounding-mode enum, fflags bit indices, EXP_INF=10'h0FF, CANON_NAN=32'h7FC00000, MAX_FINITE=32'h7F7FFFFF.
REQ-028 SHALL instantiate one combinational sub-module, float_round_inc: inputs sign, rm, lsb, round, sticky; output increment decision.

Verification
REQ-029 man 0x800000, exp 127, rb=0, sb=0, RNE -> 0x3F800000, fflags 0, valid at N+2.
REQ-030 man 0x800001, exp 127, rb=1, sb=0 -> RNE 0x3F800002 NX; RTZ 0x3F800001 NX.
REQ-031 man 0xFFFFFF, exp 127, rb=1, RNE -> 0x40000000 NX.
REQ-032 man 0x800000, exp 255, RNE -> 0x7F800000 OF|NX; same input RTZ -> 0x7F7FFFFF OF|NX.
REQ-033 exp 10'h3FF, man 0x800000, rb=0, sb=0 -> macro on: 0x00200000, flags 0, valid at N+4; macro off: 0x00000000 UF|NX at N+2.
REQ-034 final_res=1, IV=1, exp 0x0FF, man 0xC00000 -> 0x7FC00000 NV. A second load during SHIFT yields only the second result.
